// File: rtl/vram_fill_engine_pkg.sv
// Shared video constants: op-codes, fill FSM states, screen limits and the
// frame-buffer address packing used by both the fill engine and the scanner.
package vram_fill_engine_pkg;

    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int ADDR_W    = 15;
    localparam int SCR_X_MAX = 159;
    localparam int SCR_Y_MAX = 119;

    typedef enum logic [1:0] {
        OP_PIXEL = 2'b00,
        OP_RECT  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Row-major packing {y, x} plus base; the sum wraps at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [X_W-1:0]    x,
        input logic [Y_W-1:0]    y,
        input logic [ADDR_W-1:0] offset
    );
        return {y, x} + offset;
    endfunction

endpackage

// File: rtl/vram_fill_engine_if.sv
// Command and video-RAM write bundle between a command source and the fill engine.
interface vram_fill_engine_if;
    import vram_fill_engine_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [X_W-1:0]    cmd_x0;
    logic [Y_W-1:0]    cmd_y0;
    logic [X_W-1:0]    cmd_x1;
    logic [Y_W-1:0]    cmd_y1;
    logic [7:0]        cmd_color;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        input  cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        output cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );

endinterface

// File: rtl/vram_raster_counter.sv
// 2-D raster counter: x ascends inside [x_lo, x_hi], y advances on row wrap.
// Exposes the next position so the owner can register it alongside the step.
module vram_raster_counter
    import vram_fill_engine_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [X_W-1:0] x_lo,
    input  logic [X_W-1:0] x_hi,
    input  logic [Y_W-1:0] y_lo,
    input  logic [Y_W-1:0] y_hi,
    input  logic           step,
    output logic [X_W-1:0] x_next,
    output logic [Y_W-1:0] y_next,
    output logic           last
);

    logic [X_W-1:0] x_r;
    logic [X_W-1:0] x_lo_r;
    logic [X_W-1:0] x_hi_r;
    logic [Y_W-1:0] y_r;
    logic [Y_W-1:0] y_hi_r;

    // Position and bound registers: load captures a region, step advances one pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_r    <= 8'd0;
            y_r    <= 7'd0;
            x_lo_r <= 8'd0;
            x_hi_r <= 8'd0;
            y_hi_r <= 7'd0;
        end else if (load) begin
            x_r    <= x_lo;
            y_r    <= y_lo;
            x_lo_r <= x_lo;
            x_hi_r <= x_hi;
            y_hi_r <= y_hi;
        end else if (step) begin
            x_r <= x_next;
            y_r <= y_next;
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    // Raster successor of the current position.
    always_comb begin
        x_next = x_r + 8'd1;
        y_next = y_r;
        if (x_r == x_hi_r) begin
            x_next = x_lo_r;
            y_next = y_r + 7'd1;
        end else begin
            x_next = x_r + 8'd1;
            y_next = y_r;
        end
    end

    assign last = (x_r == x_hi_r) && (y_r == y_hi_r);

endmodule

// File: rtl/vram_fill_engine.sv
// Pixel / rectangle / clear-screen fill engine: one video-RAM write per cycle
// in raster order, with a one-cycle done pulse after the last write.
module vram_fill_engine
    import vram_fill_engine_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_OFFSET = 15'd1000,
    parameter int                X_MAX       = SCR_X_MAX,
    parameter int                Y_MAX       = SCR_Y_MAX
) (
    input logic               clk,
    input logic               rst_n,
    vram_fill_engine_if.slave bus
);

    localparam logic [X_W-1:0] X_MAX_V = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_MAX_V = Y_W'(Y_MAX);

    state_e            state_r;
    logic              cmd_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [7:0]        wr_data_r;
    logic [7:0]        color_r;

    logic [X_W-1:0]    x_lo_s;
    logic [X_W-1:0]    x_hi_s;
    logic [Y_W-1:0]    y_lo_s;
    logic [Y_W-1:0]    y_hi_s;
    logic              nop_s;
    logic              empty_s;
    logic              load_s;
    logic              step_s;
    logic [X_W-1:0]    x_next_s;
    logic [Y_W-1:0]    y_next_s;
    logic              last_s;

    // Region decode of the offered command, with rectangle clamping and emptiness.
    always_comb begin
        x_lo_s = bus.cmd_x0;
        x_hi_s = bus.cmd_x0;
        y_lo_s = bus.cmd_y0;
        y_hi_s = bus.cmd_y0;
        nop_s  = 1'b0;
        case (op_e'(bus.cmd_op))
            OP_PIXEL: begin
                x_hi_s = bus.cmd_x0;
                y_hi_s = bus.cmd_y0;
            end
            OP_RECT: begin
                x_hi_s = (bus.cmd_x1 > X_MAX_V) ? X_MAX_V : bus.cmd_x1;
                y_hi_s = (bus.cmd_y1 > Y_MAX_V) ? Y_MAX_V : bus.cmd_y1;
            end
            OP_CLEAR: begin
                x_lo_s = 8'd0;
                x_hi_s = X_MAX_V;
                y_lo_s = 7'd0;
                y_hi_s = Y_MAX_V;
            end
            OP_NOP:  nop_s = 1'b1;
            default: nop_s = 1'b1;
        endcase
        empty_s = nop_s || (x_lo_s > x_hi_s) || (y_lo_s > y_hi_s)
                  || (x_lo_s > X_MAX_V) || (y_lo_s > Y_MAX_V);
    end

    assign load_s = (state_r == ST_IDLE) && bus.cmd_valid && !empty_s;
    assign step_s = (state_r == ST_RUN) && !last_s;

    vram_raster_counter u_raster (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_s),
        .x_lo   (x_lo_s),
        .x_hi   (x_hi_s),
        .y_lo   (y_lo_s),
        .y_hi   (y_hi_s),
        .step   (step_s),
        .x_next (x_next_s),
        .y_next (y_next_s),
        .last   (last_s)
    );

    // Control FSM; the first pixel is written straight from the decoded
    // start corner so it lands the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= 15'd0;
            wr_data_r   <= 8'd0;
            color_r     <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        color_r     <= bus.cmd_color;
                        if (empty_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r   <= ST_RUN;
                            wr_en_r   <= 1'b1;
                            wr_addr_r <= pack_addr(x_lo_s, y_lo_s, ADDR_OFFSET);
                            wr_data_r <= bus.cmd_color;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (last_s) begin
                        state_r <= ST_DONE;
                        wr_en_r <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= pack_addr(x_next_s, y_next_s, ADDR_OFFSET);
                        wr_data_r <= color_r;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    wr_en_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;

endmodule

// File: tb/tb_vram_fill_engine.sv
// Self-checking bench for vram_fill_engine: directed vector table, random
// commands against a region/raster reference model, held-request and reset cases.
module tb_vram_fill_engine;

    typedef struct {
        logic [1:0] op;
        logic [7:0] x0;
        logic [6:0] y0;
        logic [7:0] x1;
        logic [6:0] y1;
        logic [7:0] col;
        int         n;
        int         first;
        int         last;
    } vec_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    wr_t  exp_q[$];
    wr_t  got_q[$];
    vec_t vecs[9];

    vram_fill_engine_if bus();

    vram_fill_engine #(.ADDR_OFFSET(15'd1000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: pixels a command should paint, from the region rules.
    task automatic model(input logic [1:0] op, input logic [7:0] x0, input logic [6:0] y0,
                         input logic [7:0] x1, input logic [6:0] y1, input logic [7:0] col);
        int xl, xh, yl, yh;
        exp_q.delete();
        xl = int'(x0); yl = int'(y0); xh = xl; yh = yl;
        case (op)
            2'd1: begin
                xh = (int'(x1) > 159) ? 159 : int'(x1);
                yh = (int'(y1) > 119) ? 119 : int'(y1);
            end
            2'd2: begin xl = 0; xh = 159; yl = 0; yh = 119; end
            2'd3: begin xl = 1; xh = 0; end
            default: ;
        endcase
        if (xl <= 159 && yl <= 119)
            for (int y = yl; y <= yh; y++)
                for (int x = xl; x <= xh; x++)
                    exp_q.push_back('{(y * 256 + x + 1000) % 32768, int'(col)});
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] x0, input logic [6:0] y0,
                           input logic [7:0] x1, input logic [6:0] y1, input logic [7:0] col,
                           output int n_got, output int first_a, output int last_a);
        int  done_cyc, wait_cyc, bad;
        bit  busy_ok, hold_ok;
        model(op, x0, y0, x1, y1, col);
        got_q.delete();
        wait_cyc = 0;
        while (!bus.cmd_ready && wait_cyc < 100) begin
            @(posedge clk); #1; wait_cyc++;
        end
        chk("ready_before_cmd", int'(bus.cmd_ready), 1);
        bus.cmd_op = op; bus.cmd_x0 = x0; bus.cmd_y0 = y0;
        bus.cmd_x1 = x1; bus.cmd_y1 = y1; bus.cmd_color = col;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        done_cyc = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        for (int c = 1; c <= 20000 && done_cyc == 0; c++) begin
            if (bus.done) begin
                done_cyc = c;
                if (got_q.size() > 0)
                    hold_ok = (int'(bus.wr_addr) == got_q[$].addr) && (int'(bus.wr_data) == got_q[$].data);
            end
            if (bus.wr_en) got_q.push_back('{int'(bus.wr_addr), int'(bus.wr_data)});
            if (!bus.busy) busy_ok = 1'b0;
            if (done_cyc == 0) begin @(posedge clk); #1; end
        end
        chk("done_latency", done_cyc, exp_q.size() + 1);
        chk("busy_during_cmd", int'(busy_ok), 1);
        chk("hold_when_idle", int'(hold_ok), 1);
        bad = (got_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) begin
                if (bad == 0)
                    $display("FAIL stream[%0d]: got addr %0d data %0d, expected addr %0d data %0d",
                             i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
                bad++;
            end
        chk("stream_vs_model", bad, 0);
        @(posedge clk); #1;
        chk("idle_after_done", int'({bus.cmd_ready, bus.busy, bus.done}), 4);
        n_got   = got_q.size();
        first_a = (n_got > 0) ? got_q[0].addr : -1;
        last_a  = (n_got > 0) ? got_q[$].addr : -1;
    endtask

    initial begin
        int n, fa, la, bad, c8_addr, nw;
        bit prev_ready;
        logic [1:0] op;
        logic [7:0] x0, x1;
        logic [6:0] y0, y1;

        vecs[0] = '{2'd0, 8'd10,  7'd5,   8'd0,   7'd0,   8'hE0, 1,     2290,  2290};
        vecs[1] = '{2'd1, 8'd2,   7'd1,   8'd4,   7'd2,   8'h1C, 6,     1258,  1516};
        vecs[2] = '{2'd1, 8'd5,   7'd1,   8'd3,   7'd2,   8'hAA, 0,     -1,    -1};
        vecs[3] = '{2'd1, 8'd150, 7'd110, 8'd200, 7'd127, 8'h33, 100,   29310, 31623};
        vecs[4] = '{2'd2, 8'd7,   7'd9,   8'd1,   7'd1,   8'h00, 19200, 1000,  31623};
        vecs[5] = '{2'd3, 8'd1,   7'd1,   8'd9,   7'd9,   8'h11, 0,     -1,    -1};
        vecs[6] = '{2'd0, 8'd160, 7'd5,   8'd0,   7'd0,   8'h22, 0,     -1,    -1};
        vecs[7] = '{2'd0, 8'd159, 7'd119, 8'd0,   7'd0,   8'hFF, 1,     31623, 31623};
        vecs[8] = '{2'd1, 8'd0,   7'd120, 8'd5,   7'd125, 8'h44, 0,     -1,    -1};

        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_x0 = 8'd0; bus.cmd_y0 = 7'd0;
        bus.cmd_x1 = 8'd0; bus.cmd_y1 = 7'd0; bus.cmd_color = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'({bus.cmd_ready, bus.busy, bus.done, bus.wr_en}), 8);
        chk("reset_addr_data", int'(bus.wr_addr) + int'(bus.wr_data), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].op, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].col, n, fa, la);
            chk($sformatf("vec%0d_count", i), n, vecs[i].n);
            chk($sformatf("vec%0d_first", i), fa, vecs[i].first);
            chk($sformatf("vec%0d_last", i), la, vecs[i].last);
        end

        for (int i = 0; i < 25; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd2) op = 2'd1;
            x0 = 8'($urandom_range(0, 170));
            y0 = 7'($urandom_range(0, 125));
            x1 = 8'(int'(x0) + int'($urandom_range(0, 12)) - 2);
            y1 = 7'(int'(y0) + int'($urandom_range(0, 10)) - 2);
            run_cmd(op, x0, y0, x1, y1, 8'($urandom), n, fa, la);
        end

        // Held request: a second command kept valid while the first is busy.
        bus.cmd_op = 2'd1; bus.cmd_x0 = 8'd2; bus.cmd_y0 = 7'd1;
        bus.cmd_x1 = 8'd4; bus.cmd_y1 = 7'd2; bus.cmd_color = 8'h1C;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_op = 2'd0; bus.cmd_x0 = 8'd1; bus.cmd_y0 = 7'd1; bus.cmd_color = 8'h55;
        nw = 0; c8_addr = -1; prev_ready = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (prev_ready) bus.cmd_valid = 1'b0;
            if (bus.wr_en) begin
                nw++;
                if (c == 9) c8_addr = int'(bus.wr_addr);
            end
            prev_ready = bus.cmd_ready;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        chk("held_total_writes", nw, 7);
        chk("held_second_addr", c8_addr, 1257);

        // Reset for one cycle in the middle of a clear.
        bus.cmd_op = 2'd2; bus.cmd_color = 8'h00; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("clear_running", int'({bus.wr_en, bus.busy}), 3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_outputs", int'({bus.cmd_ready, bus.busy, bus.done, bus.wr_en}), 8);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.wr_en || bus.done) bad++;
            @(posedge clk); #1;
        end
        chk("abort_quiet", bad, 0);
        run_cmd(2'd0, 8'd10, 7'd5, 8'd0, 7'd0, 8'hE0, n, fa, la);
        chk("after_abort_pixel", fa, 2290);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vram_fill_engine.md
VRAM_FILL_ENGINE -- requirements
Module: vram_fill_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_OFFSET, 15'd1000, frame-buffer base added to every packed address.
  X_MAX, 159, last visible column (160 columns, 8-bit x).
  Y_MAX, 119, last visible row (120 rows, 7-bit y).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk        in   1   single clock; all logic on rising edge.
  rst_n      in   1   synchronous reset, active-low.
  cmd_valid  in   1   command offered.
  cmd_ready  out  1   engine can accept a command.
  cmd_op     in   2   00 pixel, 01 rectangle, 10 clear screen, 11 no-op.
  cmd_x0     in   8   start column.
  cmd_y0     in   7   start row.
  cmd_x1     in   8   end column (rectangle only).
  cmd_y1     in   7   end row (rectangle only).
  cmd_color  in   8   RGB332 colour written.
  wr_en      out  1   video-RAM write strobe.
  wr_addr    out  15  video-RAM write address.
  wr_data    out  8   video-RAM write data.
  busy       out  1   command in progress (state RUN or DONE).
  done       out  1   one-cycle pulse on command completion.

Function
REQ-003 FSM states SHALL be IDLE, RUN, DONE; cmd_ready = 1 only in IDLE.
REQ-004 A command is accepted on a rising edge with cmd_valid && cmd_ready; all cmd_* fields are latched on that edge.
REQ-005 On acceptance the FSM SHALL go to RUN with the latched bounds, or straight to DONE if the region is empty.
REQ-006 Pixel op SHALL set region x0..x0, y0..y0; clear op SHALL set region 0..X_MAX, 0..Y_MAX; no-op SHALL set an empty region.
REQ-007 Rectangle bounds SHALL be clamped: x1 to X_MAX, y1 to Y_MAX. Region is empty if x0 > clamped x1, y0 > clamped y1, x0 > X_MAX or y0 > Y_MAX.
REQ-008 In RUN the engine SHALL emit exactly one write per cycle in raster order: x inner (ascending), y outer (ascending).
REQ-009 wr_addr SHALL equal {y[6:0], x[7:0]} + ADDR_OFFSET, computed modulo 2^15. This is the same mapping the display scanner uses to read.
REQ-010 wr_en, wr_addr and wr_data SHALL be registered outputs. The first write appears in the cycle after acceptance.
REQ-011 A region of W×H pixels SHALL produce exactly W*H consecutive wr_en cycles.
REQ-012 The FSM SHALL enter DONE in the cycle after the last write. DONE lasts one cycle with done = 1, then returns to IDLE.
REQ-013 cmd_valid asserted outside IDLE SHALL be ignored; a held request is accepted on the first IDLE cycle.
REQ-014 When wr_en = 0, wr_addr and wr_data SHALL hold their last values.

Reset
REQ-015 While rst_n = 0 at a clock edge, all of the following SHALL be cleared: FSM = IDLE, cmd_ready = 1, busy = 0, done = 0, wr_en = 0, wr_addr = 0, wr_data = 0, x/y counters = 0.
REQ-016 Reset during RUN SHALL abort the fill immediately: no further writes and no done pulse.

Structure
REQ-017 Op-code constants, FSM state encodings, X_MAX/Y_MAX and the address-packing width SHALL reside in the shared video package. The display scanner uses the same package.
REQ-018 One sub-module is natural: vram_raster_counter, a 2-D x/y counter with load bounds, step and last-pixel flag.

Verification
REQ-019 Pixel (x=10, y=5, colour 0xE0) -> exactly one write, addr 2290, data 0xE0; done two cycles after acceptance.
REQ-020 Rectangle x 2..4, y 1..2, colour 0x1C -> 6 writes at addr 1258, 1259, 1260, 1514, 1515, 1516, then done.
REQ-021 Clear, colour 0x00 -> 19200 consecutive writes, first addr 1000, last addr 31623; busy high throughout.
REQ-022 Inverted rectangle x0=5, x1=3 -> zero writes; done pulses the cycle after acceptance.
REQ-023 Rectangle x1=200, y1=127 with x0=150, y0=110 -> clamped to 10×10 = 100 writes; last addr 31623.
REQ-024 rst_n low for one cycle mid-clear -> wr_en = 0 from the next cycle, no done pulse, cmd_ready = 1.
